led_pattern_pwm: RTL and testbench
==================================

LED_PATTERN_PWM -- requirements
Module: led_pattern_pwm

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000: clock frequency in Hz, documentation only, no functional effect.
REQ-002 SHALL have parameter N_LEDS, default 8: LED channel count, legal range 1..32.
REQ-003 SHALL have parameter PWM_BITS, default 8: PWM resolution, legal range 2..12; MAX = 2^PWM_BITS-1.
REQ-004 SHALL have parameter STEP_PERIODS, default 392: PWM periods per pattern step, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port mode, input, 2 bits: pattern select; 0=ALT, 1=BREATHE, 2=CHASE, 3=OFF.
REQ-008 SHALL have port leds, output, N_LEDS bits: registered LED drive, 1 = lit.
REQ-009 SHALL have port pwm_sync, output, 1 bit: registered one-cycle pulse marking the end of each PWM period.

Function
REQ-010 pwm_cnt (PWM_BITS wide) SHALL increment every cycle and wrap MAX->0; period_end is true when pwm_cnt==MAX.
REQ-011 pwm_sync SHALL be 1 exactly in the cycle after each period_end cycle, 0 otherwise.
REQ-012 step_cnt SHALL advance on period_end; a step event occurs when step_cnt==STEP_PERIODS-1 at period_end, and step_cnt then returns to 0.
REQ-013 mode SHALL be sampled into mode_q only at period_end; between samples, changes on mode SHALL have no effect.
REQ-014 When the sampled mode differs from mode_q, the block SHALL load that mode's initial state, clear step_cnt, and suppress any coincident step event.
REQ-015 ALT: initial mask bit i = ~i[0] (0x55 for 8 LEDs), duty = MAX; each step inverts the mask.
REQ-016 BREATHE: initial level=0, dir=up, mask all ones, duty=level; each step moves level by 1 in direction dir.
REQ-017 BREATHE direction SHALL flip down on reaching MAX and flip up on reaching 0, with no overshoot or wrap.
REQ-018 CHASE: initial mask one-hot bit 0, duty = MAX; each step rotates the mask left, bit N_LEDS-1 wrapping to bit 0; for N_LEDS=1 the mask stays 1.
REQ-019 OFF: mask = 0; all state other than pwm_cnt and step_cnt SHALL hold.
REQ-020 leds[i] SHALL be registered as mask[i] AND (pwm_cnt < duty), giving one cycle of latency from pwm_cnt.
REQ-021 Duty = MAX SHALL give leds low only in the cycle after pwm_cnt==MAX; duty = 0 SHALL give leds constantly low.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL set pwm_cnt=0, step_cnt=0, mode_q=ALT with ALT initial mask, level=0, dir=up, leds=0, pwm_sync=0.
REQ-023 Reset asserted mid-period or mid-ramp SHALL discard all state; the first active cycle SHALL behave as pwm_cnt=0.

Configuration
REQ-024 Macro LED_PATTERN_GAMMA_EN: when defined, BREATHE duty SHALL be (level*level)>>PWM_BITS, computed at full 2*PWM_BITS width before the shift.
REQ-025 Without LED_PATTERN_GAMMA_EN, BREATHE duty SHALL be level (linear); ALT, CHASE and OFF are unaffected either way.

Verification (N_LEDS=8, PWM_BITS=4, STEP_PERIODS=2, mode=0 unless stated)
REQ-026 Reset release -> leds=0x00 in cycle 0, then 0x55 in cycles 1..15, 0x00 in cycle 16, pwm_sync pulse at cycle 16.
REQ-027 ALT stepping -> mask 0x55 becomes 0xAA after 32 cycles and returns to 0x55 after 64 cycles.
REQ-028 Set mode=1 mid-period -> no change until period_end; then leds=0 for a full 32 cycles, then lit 1 of 16 cycles; ramp reaches 15, then descends 14, 13, ...
REQ-029 mode=2 -> mask sequence 0x01, 0x02, ..., 0x80, 0x01, advancing every 32 cycles.
REQ-030 mode=3 -> leds=0 from the cycle after the latching period_end; return to mode=0 restarts at 0x55.
REQ-031 BREATHE at level=8 -> leds lit 4 cycles per period with LED_PATTERN_GAMMA_EN, 8 cycles per period without it.

Source files
------------

// File: rtl/led_pattern_pwm.sv
// led_pattern_pwm: PWM-dimmed LED patterns (ALT, BREATHE, CHASE, OFF) stepped every STEP_PERIODS PWM periods.
// Optional macro LED_PATTERN_GAMMA_EN squares the BREATHE level for a perceptual ramp.
module led_pattern_pwm #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int N_LEDS       = 8,
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 392
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              pwm_sync
);
    typedef enum logic [1:0] {ALT, BREATHE, CHASE, OFF} mode_t;
    localparam int SW = $clog2(STEP_PERIODS + 1);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [31:0] ALT_32 = 32'h5555_5555;
    localparam logic [N_LEDS-1:0] ALT_INIT = ALT_32[N_LEDS-1:0];
    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
    logic [PWM_BITS-1:0] pwm_cnt, level, level_nx, duty, breathe_duty;
    logic [SW-1:0]       step_cnt;
    logic [N_LEDS-1:0]   mask, mask_nx;
    logic                dir, dir_nx, period_end, change, step;
    mode_t               mode_q, mode_in;
    assign mode_in    = mode_t'(mode);
    assign period_end = pwm_cnt == MAX;
    assign change     = period_end && mode_in != mode_q;
    // a mode switch takes priority and swallows a coincident step
    assign step       = period_end && step_cnt == STEP_LAST && !change;
`ifdef LED_PATTERN_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq     = level * level;
    assign breathe_duty = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign breathe_duty = level;
`endif
    assign duty = mode_q == BREATHE ? breathe_duty : MAX;
    always_comb begin
        mask_nx  = mask;
        level_nx = level;
        dir_nx   = dir;
        if (change) begin
            mask_nx = mode_in == ALT ? ALT_INIT : mode_in == BREATHE ? '1 : mode_in == CHASE ? ONE : '0;
            if (mode_in == BREATHE) begin
                level_nx = '0;
                dir_nx   = 1'b0;
            end
        end else if (step) begin
            if (mode_q == ALT)
                mask_nx = ~mask;
            else if (mode_q == CHASE)
                mask_nx = (mask << 1) | (mask >> (N_LEDS - 1));
            else if (mode_q == BREATHE) begin
                level_nx = dir ? level - 1'b1 : level + 1'b1;
                dir_nx   = level_nx == MAX ? 1'b1 : level_nx == '0 ? 1'b0 : dir;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
            mode_q   <= ALT;
            mask     <= ALT_INIT;
            level    <= '0;
            dir      <= 1'b0;
            leds     <= '0;
            pwm_sync <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            step_cnt <= (change || step) ? '0 : period_end ? step_cnt + 1'b1 : step_cnt;
            mode_q   <= period_end ? mode_in : mode_q;
            mask     <= mask_nx;
            level    <= level_nx;
            dir      <= dir_nx;
            leds     <= pwm_cnt < duty ? mask : '0;
            pwm_sync <= period_end;
        end
    end
endmodule

// File: tb/tb_led_pattern_pwm.sv
// tb_led_pattern_pwm: scoreboard bench; a behavioural model queues expected outputs each edge, compared on the falling edge.
module tb_led_pattern_pwm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] leds;
    logic       pwm_sync;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [8:0] sb[$];

    led_pattern_pwm #(.CLK_FREQ(1000), .N_LEDS(8), .PWM_BITS(4), .STEP_PERIODS(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .leds(leds), .pwm_sync(pwm_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // model keeps pattern phase (alt phase, chase index, level/dir) rather than a mask
    int m_pwm, m_step, m_mode, alt_ph, idx, lvl, dir, duty;
    logic [7:0] pat, e_leds;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pwm = 0; m_step = 0; m_mode = 0; alt_ph = 0; idx = 0; lvl = 0; dir = 0;
            sb.push_back(9'd0);
        end else begin
`ifdef LED_PATTERN_GAMMA_EN
            duty = (m_mode == 1) ? (lvl * lvl) / 16 : 15;
`else
            duty = (m_mode == 1) ? lvl : 15;
`endif
            case (m_mode)
                0: pat = alt_ph ? 8'hAA : 8'h55;
                1: pat = 8'hFF;
                2: pat = 8'(1 << idx);
                default: pat = 8'h00;
            endcase
            e_leds = (m_pwm < duty) ? pat : 8'h00;
            sb.push_back({e_leds, m_pwm == 15});
            if (m_pwm == 15) begin
                if (int'(mode) != m_mode) begin
                    m_mode = int'(mode); m_step = 0; alt_ph = 0; idx = 0;
                    if (m_mode == 1) begin lvl = 0; dir = 0; end
                end else if (m_step == 1) begin
                    m_step = 0;
                    if (m_mode == 0) alt_ph = 1 - alt_ph;
                    else if (m_mode == 2) idx = (idx + 1) % 8;
                    else if (m_mode == 1) begin
                        if (dir == 0) begin lvl++; if (lvl == 15) dir = 1; end
                        else begin lvl--; if (lvl == 0) dir = 0; end
                    end
                end else m_step++;
            end
            m_pwm = (m_pwm + 1) % 16;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("leds", leds, e[8:1]);
            check("pwm_sync", {7'd0, pwm_sync}, {7'd0, e[0]});
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_leds", leds, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_c1", leds, 8'h55);
        repeat (15) @(negedge clk);
        check("release_c16", leds, 8'h00);
        check("release_sync", {7'd0, pwm_sync}, 8'd1);
        @(negedge clk);
        check("release_c17", leds, 8'h55);
        repeat (90) @(negedge clk);
        repeat (5) @(negedge clk);
        mode = 2'd1;
        repeat (3) @(negedge clk);
        mode = 2'd2;
        @(negedge clk);
        mode = 2'd1;
        repeat (32 * 34) @(negedge clk);
        mode = 2'd2;
        repeat (32 * 9 + 7) @(negedge clk);
        mode = 2'd3;
        repeat (100) @(negedge clk);
        mode = 2'd0;
        repeat (100) @(negedge clk);
        mode = 2'd1;
        repeat (32 * 9 + 3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_c1", leds, 8'h55);
        repeat (200) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
